// File: rtl/breather_pkg.sv
// Shared encodings for the breathing-light controller family.
package breather_pkg;

    localparam logic [1:0] MODE_BREATHE = 2'd0;
    localparam logic [1:0] MODE_STEADY  = 2'd1;
    localparam logic [1:0] MODE_BLINK   = 2'd2;
    localparam logic [1:0] MODE_OFF     = 2'd3;

    localparam logic DIR_DOWN = 1'b0;
    localparam logic DIR_UP   = 1'b1;

endpackage

// File: rtl/pwm_mask.sv
// Free-running PWM counter and compare: on_o is high for level_i of every 2**PWM_BITS cycles.
module pwm_mask #(
    parameter int unsigned PWM_BITS = 4
) (
    input  logic                clk_i,
    input  logic                rst_n_i,
    input  logic                en_i,
    input  logic [PWM_BITS-1:0] level_i,
    output logic                on_o
);

    localparam logic [PWM_BITS-1:0] MAX = '1;

    logic [PWM_BITS-1:0] pwm_cnt_q;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            pwm_cnt_q <= '0;
        end else if (en_i) begin
            pwm_cnt_q <= pwm_cnt_q + PWM_BITS'(1);
        end
    end

    // Top level is forced fully on; a plain compare would leave one dark slot per period.
    assign on_o = (level_i == MAX) || (pwm_cnt_q < level_i);

endmodule

// File: rtl/breather_multi.sv
// Multi-channel breathing-light controller: mode/level sequencer driving a shared PWM mask.
module breather_multi
    import breather_pkg::*;
#(
    parameter int unsigned CHANNELS    = 3,
    parameter int unsigned PWM_BITS    = 4,
    parameter int unsigned STEP_CYCLES = 9765625,
    parameter int unsigned STEP_W      = 32
) (
    input  logic                clk_i,
    input  logic                rst_n_i,
    input  logic                en_i,
    input  logic [1:0]          mode_i,
    input  logic [PWM_BITS-1:0] level_i,
    input  logic [CHANNELS-1:0] rgb_i,
    output logic [CHANNELS-1:0] rgb_o,
    output logic [PWM_BITS-1:0] level_o,
    output logic                peak_o
);

    localparam logic [PWM_BITS-1:0] MAX       = '1;
    localparam logic [STEP_W-1:0]   STEP_LAST = STEP_W'(STEP_CYCLES - 1);

    logic [1:0]          mode_q;
    logic [STEP_W-1:0]   step_q, step_d;
    logic [PWM_BITS-1:0] level_q, level_d;
    logic                dir_q, dir_d;
    logic                peak_q, peak_d;
    logic [CHANNELS-1:0] rgb_q, rgb_d;
    logic                tick;
    logic                mask_on;

    pwm_mask #(
        .PWM_BITS(PWM_BITS)
    ) u_pwm_mask (
        .clk_i  (clk_i),
        .rst_n_i(rst_n_i),
        .en_i   (en_i),
        .level_i(level_q),
        .on_o   (mask_on)
    );

    assign tick = en_i && (step_q == STEP_LAST);

    always_comb begin
        step_d  = step_q;
        level_d = level_q;
        dir_d   = dir_q;
        peak_d  = 1'b0;
        rgb_d   = en_i ? (rgb_i & {CHANNELS{mask_on}}) : '0;
        // A mode change always restarts the sequence, even while frozen, so it is never lost.
        if (mode_i != mode_q) begin
            step_d = '0;
            dir_d  = DIR_DOWN;
            unique case (mode_i)
                MODE_BREATHE: level_d = MAX;
                MODE_STEADY:  level_d = level_i;
                MODE_BLINK:   level_d = MAX;
                MODE_OFF:     level_d = '0;
            endcase
        end else if (en_i) begin
            step_d = tick ? '0 : step_q + STEP_W'(1);
            unique case (mode_q)
                MODE_BREATHE: begin
                    if (tick) begin
                        if (dir_q == DIR_DOWN) begin
                            if (level_q == '0) begin
                                dir_d   = DIR_UP;
                                level_d = PWM_BITS'(1);
                                peak_d  = 1'b1;
                            end else begin
                                level_d = level_q - PWM_BITS'(1);
                            end
                        end else begin
                            if (level_q == MAX) begin
                                dir_d   = DIR_DOWN;
                                level_d = MAX - PWM_BITS'(1);
                                peak_d  = 1'b1;
                            end else begin
                                level_d = level_q + PWM_BITS'(1);
                            end
                        end
                    end
                end
                MODE_STEADY: level_d = level_i;
                MODE_BLINK: begin
                    if (tick) begin
                        level_d = (level_q == '0) ? MAX : '0;
                    end
                end
                MODE_OFF: level_d = '0;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            mode_q  <= MODE_BREATHE;
            step_q  <= '0;
            level_q <= MAX;
            dir_q   <= DIR_DOWN;
            peak_q  <= 1'b0;
            rgb_q   <= '0;
        end else begin
            mode_q  <= mode_i;
            step_q  <= step_d;
            level_q <= level_d;
            dir_q   <= dir_d;
            peak_q  <= peak_d;
            rgb_q   <= rgb_d;
        end
    end

    assign rgb_o   = rgb_q;
    assign level_o = level_q;
    assign peak_o  = peak_q;

endmodule
